// File: rtl/gemm_tiled_controller.sv
// Tiled M x N x K GeMM loop sequencer: K innermost, runtime-selectable outer order,
// valid/ready operand beats and a registered result port. Optional perf counters: GEMM_CTRL_PERF_EN.
module gemm_tiled_controller #(
  parameter int unsigned AddrWidth = 16,
  parameter int unsigned PerfWidth = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 start_i,
  input  logic                 loop_order_i,
  input  logic [AddrWidth-1:0] M_size_i,
  input  logic [AddrWidth-1:0] K_size_i,
  input  logic [AddrWidth-1:0] N_size_i,
  input  logic                 input_valid_i,
  output logic                 input_ready_o,
  output logic                 acc_clear_o,
  output logic [AddrWidth-1:0] M_count_o,
  output logic [AddrWidth-1:0] N_count_o,
  output logic [AddrWidth-1:0] K_count_o,
  output logic                 result_valid_o,
  input  logic                 result_ready_i,
  output logic [AddrWidth-1:0] result_m_o,
  output logic [AddrWidth-1:0] result_n_o,
  output logic                 busy_o,
`ifdef GEMM_CTRL_PERF_EN
  output logic [PerfWidth-1:0] perf_busy_cycles_o,
  output logic [PerfWidth-1:0] perf_stall_cycles_o,
`endif
  output logic                 done_o
);

  typedef enum logic [1:0] {IDLE, BUSY, DRAIN, FINISH} state_e;

  localparam logic [AddrWidth-1:0] One = AddrWidth'(1);

  state_e               state_q, state_d;
  logic [AddrWidth-1:0] m_q, m_d, n_q, n_d, k_q, k_d;
  logic [AddrWidth-1:0] msz_q, msz_d, nsz_q, nsz_d, ksz_q, ksz_d;
  logic [AddrWidth-1:0] res_m_q, res_m_d, res_n_q, res_n_d;
  logic                 order_q, order_d, res_valid_q, res_valid_d;
  logic                 in_ready, beat, res_set;
  logic                 m_end, n_end, k_end;

  assign m_end = (m_q == msz_q - One);
  assign n_end = (n_q == nsz_q - One);
  assign k_end = (k_q == ksz_q - One);

  always_comb begin
    state_d     = state_q;
    m_d         = m_q;
    n_d         = n_q;
    k_d         = k_q;
    msz_d       = msz_q;
    nsz_d       = nsz_q;
    ksz_d       = ksz_q;
    order_d     = order_q;
    in_ready    = 1'b0;
    beat        = 1'b0;
    res_set     = 1'b0;
    done_o      = 1'b0;
    res_valid_d = res_valid_q;
    res_m_d     = res_m_q;
    res_n_d     = res_n_q;

    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          msz_d   = M_size_i;
          nsz_d   = N_size_i;
          ksz_d   = K_size_i;
          order_d = loop_order_i;
          m_d     = '0;
          n_d     = '0;
          k_d     = '0;
          if (M_size_i == '0 || N_size_i == '0 || K_size_i == '0) state_d = FINISH;
          else                                                    state_d = BUSY;
        end
      end
      BUSY: begin
        in_ready = !(res_valid_q && !result_ready_i);
        beat     = input_valid_i && in_ready;
        if (beat) begin
          if (!k_end) begin
            k_d = k_q + One;
          end else begin
            k_d     = '0;
            res_set = 1'b1;
            // order 0: n is the middle loop; order 1: m is the middle loop
            if (!order_q) begin
              if (n_end) begin
                n_d = '0;
                m_d = m_end ? '0 : m_q + One;
              end else begin
                n_d = n_q + One;
              end
            end else begin
              if (m_end) begin
                m_d = '0;
                n_d = n_end ? '0 : n_q + One;
              end else begin
                m_d = m_q + One;
              end
            end
            if (m_end && n_end) state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (!res_valid_q || result_ready_i) state_d = FINISH;
      end
      FINISH: begin
        done_o  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // a set in the same cycle as an accept keeps valid high with fresh indices
    if (res_set) begin
      res_valid_d = 1'b1;
      res_m_d     = m_q;
      res_n_d     = n_q;
    end else if (res_valid_q && result_ready_i) begin
      res_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      m_q         <= '0;
      n_q         <= '0;
      k_q         <= '0;
      msz_q       <= '0;
      nsz_q       <= '0;
      ksz_q       <= '0;
      order_q     <= 1'b0;
      res_valid_q <= 1'b0;
      res_m_q     <= '0;
      res_n_q     <= '0;
    end else begin
      state_q     <= state_d;
      m_q         <= m_d;
      n_q         <= n_d;
      k_q         <= k_d;
      msz_q       <= msz_d;
      nsz_q       <= nsz_d;
      ksz_q       <= ksz_d;
      order_q     <= order_d;
      res_valid_q <= res_valid_d;
      res_m_q     <= res_m_d;
      res_n_q     <= res_n_d;
    end
  end

  assign input_ready_o  = in_ready;
  assign acc_clear_o    = beat && (k_q == '0);
  assign M_count_o      = m_q;
  assign N_count_o      = n_q;
  assign K_count_o      = k_q;
  assign result_valid_o = res_valid_q;
  assign result_m_o     = res_m_q;
  assign result_n_o     = res_n_q;
  assign busy_o         = (state_q != IDLE);

`ifdef GEMM_CTRL_PERF_EN
  logic [PerfWidth-1:0] pbusy_q, pstall_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pbusy_q  <= '0;
      pstall_q <= '0;
    end else if (state_q == IDLE && start_i) begin
      pbusy_q  <= '0;
      pstall_q <= '0;
    end else begin
      if (busy_o && pbusy_q != '1) pbusy_q <= pbusy_q + 1'b1;
      if (state_q == BUSY && input_valid_i && !in_ready && pstall_q != '1)
        pstall_q <= pstall_q + 1'b1;
    end
  end

  assign perf_busy_cycles_o  = pbusy_q;
  assign perf_stall_cycles_o = pstall_q;
`endif

endmodule
